// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle between the board-side master and the burst memory slave.
// The master modport drives the SPI inputs; the slave modport drives MISO and status.
interface spi_memory_burst_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic fault_pin;
  logic miso_pin;
  logic miso_oe;
  logic busy;

  modport master (
    output sclk_pin, cs_pin, mosi_pin, fault_pin,
    input  miso_pin, miso_oe, busy
  );

  modport slave (
    input  sclk_pin, cs_pin, mosi_pin, fault_pin,
    output miso_pin, miso_oe, busy
  );
endinterface

// File: rtl/spi_memory_burst.sv
// SPI slave with a parametrised register-file RAM: burst reads/writes with
// address auto-increment and wrap, synchronised pins and fault-suppressed writes.
module spi_memory_burst #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  spi_memory_burst_if.slave bus
);
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RW, S_WRITE, S_READ} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_sync_vld;
  logic                   r_sclk_prev, r_armed;
  logic                   w_sclk, w_cs, w_mosi, w_sclk_rise, w_sclk_fall, w_go_idle;

  logic [CW-1:0]          r_bit_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data, r_shift_out, r_ram_q;
  logic                   r_miso, r_wr_pend, r_rd_vld_p0, r_rd_vld_p1;
  logic [DATA_WIDTH-1:0]  r_mem [0:(1 << ADDR_WIDTH) - 1];

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_go_idle   = (r_state != S_IDLE) && w_cs;

  // Pin synchronisers. r_armed blocks a frame already in progress at reset
  // until cs has been seen high through a fully refilled synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sync_vld  <= '0;
      r_sclk_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_pin};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_pin};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_pin};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      if (w_cs && r_sync_vld[SYNC_STAGES-1]) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_armed && !w_cs) w_state_nxt = S_ADDR;
      S_ADDR:  if (w_sclk_rise && r_bit_cnt == ADDR_LAST) w_state_nxt = S_RW;
      S_RW:    if (w_sclk_rise) w_state_nxt = w_mosi ? S_READ : S_WRITE;
      default: w_state_nxt = r_state;
    endcase
    if (w_go_idle) w_state_nxt = S_IDLE;
  end

  // Shift/count datapath; cs deassertion wins over a coincident sclk edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_shift_out <= '0;
      r_miso      <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_wr_pend   <= 1'b0;
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= r_rd_vld_p0;
      if (r_rd_vld_p1) r_shift_out <= r_ram_q;
      if (r_wr_pend)   r_addr      <= r_addr + 1'b1;
      if (w_go_idle) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_bit_cnt <= '0;
          S_ADDR: if (w_sclk_rise) begin
            r_addr    <= {r_addr[ADDR_WIDTH-2:0], w_mosi};
            r_bit_cnt <= (r_bit_cnt == ADDR_LAST) ? '0 : r_bit_cnt + 1'b1;
          end
          S_RW: if (w_sclk_rise) begin
            r_bit_cnt   <= '0;
            r_rd_vld_p0 <= w_mosi;
          end
          S_WRITE: if (w_sclk_rise) begin
            r_data <= {r_data[DATA_WIDTH-2:0], w_mosi};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_wr_pend <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_READ: if (w_sclk_fall) begin
            r_miso      <= r_shift_out[DATA_WIDTH-1];
            r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt   <= '0;
              r_addr      <= r_addr + 1'b1;
              r_rd_vld_p0 <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  // Single-port RAM: write commit and read issue never fall on the same clk.
  always_ff @(posedge clk) begin
    if (r_wr_pend && !reset && !bus.fault_pin) r_mem[r_addr] <= r_data;
    if (r_rd_vld_p0) r_ram_q <= r_mem[r_addr];
  end

  assign bus.miso_pin = r_miso;
  assign bus.miso_oe  = (r_state == S_READ);
  assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: SPI master tasks drive frames, an array model
// predicts read data into a queue and a MISO monitor pops and compares.
module tb_spi_memory_burst;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_memory_burst_if bus();

  spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [7:0] model [0:127];
  logic [7:0] wq[$];
  logic [7:0] sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic sbit(input logic b);
    bus.mosi_pin = b;
    repeat (HALF) @(negedge clk);
    bus.sclk_pin = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk_pin = 1'b0;
  endtask

  task automatic cs_begin();
    bus.cs_pin = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("busy_frame_start", 32'(bus.busy), 32'd1);
    chk("oe_addr_phase", 32'(bus.miso_oe), 32'd0);
    chk("miso_addr_phase", 32'(bus.miso_pin), 32'd0);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    bus.cs_pin = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("busy_after_frame", 32'(bus.busy), 32'd0);
  endtask

  task automatic hdr(input logic [6:0] a, input logic rw);
    for (int i = 6; i >= 0; i--) sbit(a[i]);
    sbit(rw);
  endtask

  // Writes n full words from wq, then the first pbits bits of wq[n] as a partial word.
  task automatic do_write(input logic [6:0] a, input int n, input logic flt, input int pbits);
    logic [6:0] aa;
    bus.fault_pin = flt;
    cs_begin();
    hdr(a, 1'b0);
    chk("oe_write_phase", 32'(bus.miso_oe), 32'd0);
    for (int w = 0; w < n; w++) begin
      for (int b = 7; b >= 0; b--) sbit(wq[w][b]);
      aa = a + 7'(w);
      if (!flt) model[aa] = wq[w];
    end
    for (int b = 7; b > 7 - pbits; b--) sbit(wq[n][b]);
    cs_end();
    bus.fault_pin = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input int n);
    logic [6:0] aa;
    for (int w = 0; w < n; w++) begin
      aa = a + 7'(w);
      sb_q.push_back(model[aa]);
    end
    cs_begin();
    hdr(a, 1'b1);
    for (int i = 0; i < 8 * n; i++) begin
      sbit(1'($urandom));
      if (i == 0) begin
        chk("oe_read_phase", 32'(bus.miso_oe), 32'd1);
        chk("busy_read_phase", 32'(bus.busy), 32'd1);
      end
    end
    cs_end();
  endtask

  // Monitor: master samples MISO on each rising sclk while the slave drives it.
  initial begin : monitor
    int nbits;
    logic [7:0] sh;
    logic [7:0] exp;
    nbits = 0;
    sh    = '0;
    forever begin
      @(posedge bus.sclk_pin or posedge bus.cs_pin or posedge reset);
      if (bus.cs_pin === 1'b1 || reset === 1'b1) begin
        nbits = 0;
      end else if (bus.miso_oe === 1'b1) begin
        sh = {sh[6:0], bus.miso_pin};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected_word actual=0x%0h expected=none", sh);
          end else begin
            exp = sb_q.pop_front();
            chk("rd_word", 32'(sh), 32'(exp));
          end
        end
      end
    end
  end

  initial begin : stim
    logic [6:0] a;
    int n, pb;
    logic f;
    reset = 1'b1;
    bus.cs_pin = 1'b1;
    bus.sclk_pin = 1'b0;
    bus.mosi_pin = 1'b0;
    bus.fault_pin = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_miso", 32'(bus.miso_pin), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Fill the whole RAM so every later read has a known expectation.
    wq.delete();
    for (int k = 0; k < 129; k++) wq.push_back(8'($urandom));
    do_write(7'h00, 128, 1'b0, 0);

    wq = '{8'hDB};
    do_write(7'h5A, 1, 1'b0, 0);
    do_read(7'h5A, 1);

    wq = '{8'h11, 8'h22, 8'h33, 8'h00};
    do_write(7'h7E, 3, 1'b0, 0);
    do_read(7'h7E, 3);
    do_read(7'h00, 1);

    wq = '{8'hA5, 8'h00};
    do_write(7'h10, 1, 1'b0, 0);
    wq = '{8'h3C};
    do_write(7'h10, 0, 1'b0, 5);
    do_read(7'h10, 1);

    wq = '{8'h0F, 8'h00};
    do_write(7'h20, 1, 1'b0, 0);
    wq = '{8'hF0, 8'h00};
    do_write(7'h20, 1, 1'b1, 0);
    do_read(7'h20, 1);
    do_write(7'h20, 1, 1'b0, 0);
    do_read(7'h20, 1);

    // Reset in the middle of a read, with the frame still selected afterwards.
    cs_begin();
    hdr(7'h7E, 1'b1);
    for (int i = 0; i < 3; i++) sbit(1'($urandom));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_miso", 32'(bus.miso_pin), 32'd0);
    chk("rst_mid_oe", 32'(bus.miso_oe), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) sbit(1'($urandom));
    chk("rst_stale_frame_busy", 32'(bus.busy), 32'd0);
    cs_end();
    do_read(7'h7E, 1);

    for (int t = 0; t < 6; t++) begin
      a  = 7'($urandom);
      n  = $urandom_range(1, 4);
      f  = ($urandom_range(0, 3) == 0);
      pb = $urandom_range(0, 7);
      wq.delete();
      for (int k = 0; k <= n; k++) wq.push_back(8'($urandom));
      do_write(a, n, f, pb);
      do_read(a, n);
    end

    // sclk/mosi activity with cs high must be ignored entirely.
    bus.cs_pin = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.mosi_pin = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk_pin = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      chk("iso_busy", 32'(bus.busy), 32'd0);
      chk("iso_oe", 32'(bus.miso_oe), 32'd0);
      chk("iso_miso", 32'(bus.miso_pin), 32'd0);
      repeat (HALF - HALF / 2) @(negedge clk);
      bus.sclk_pin = 1'b0;
    end
    repeat (HALF) @(negedge clk);

    do_read(7'h00, 128);

    repeat (4 * HALF) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_memory_burst.md
Name: spi_memory_burst

Overview:
- Parametrised SPI slave memory, successor to the fixed 8-bit SPI memory.
- Sits between the board SPI pins and an internal register-file RAM. Supports configurable address and data widths, and multi-word burst reads and writes with address auto-increment and wrap.
- Keeps the fault-injection input and adds a sync/edge-detect front end, a tri-state enable and a status output.
- All logic runs on the FPGA clock. SPI pins are treated as asynchronous inputs.

Parameters:
- ADDR_WIDTH, 7: address bits. Depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8: bits per memory word.
- SYNC_STAGES, 2: flip-flop stages on each of sclk_pin, cs_pin and mosi_pin, minimum 2.

Ports:
- clk  input  1  FPGA clock. All state updates on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- sclk_pin  input  1  SPI clock from the master, asynchronous.
- cs_pin  input  1  SPI chip select, active-low, asynchronous.
- mosi_pin  input  1  Master out, slave in, asynchronous.
- fault_pin  input  1  Fault injection. While high, memory writes are suppressed.
- miso_pin  output  1  Master in, slave out. Registered.
- miso_oe  output  1  Output enable for the external MISO buffer.
- busy  output  1  High while a transaction is selected (state != IDLE).

Behaviour:
- Front end
  - sclk, cs and mosi each pass through SYNC_STAGES flip-flops before use.
  - sclk_rise / sclk_fall are one-clk pulses derived from the last two synchronised sclk samples.
  - Master constraint: each sclk half-period is at least SYNC_STAGES+3 clk cycles.
- Frame (all fields MSB first)
  - ADDR_WIDTH address bits, then 1 R/W bit (1 = read, 0 = write), then any number of DATA_WIDTH-bit words.
  - MOSI is sampled on sclk_rise. MISO changes only on sclk_fall.
- States: IDLE, ADDR, RW, WRITE, READ.
  - IDLE -> ADDR when synchronised cs goes low. Bit counter cleared.
  - ADDR: shift mosi into addr_reg on each sclk_rise. After ADDR_WIDTH bits -> RW.
  - RW: on sclk_rise, capture the R/W bit.
    - Read: -> READ, and issue a RAM read of addr_reg on the next clk.
    - Write: -> WRITE.
  - WRITE: shift mosi into data_reg on each sclk_rise.
    - On the DATA_WIDTH-th bit: the following clk writes mem[addr_reg] = assembled word, unless fault_pin is high on that clk.
    - Then addr_reg increments and the bit counter clears.
  - READ: RAM read data is loaded into shift_out one clk after the read is issued.
    - On each sclk_fall, miso_pin is driven with shift_out MSB, then shift_out shifts left.
    - The first data bit appears on the first sclk_fall after the R/W rising edge.
    - After DATA_WIDTH falls, addr_reg increments and the next word is read and loaded before the next sclk_fall.
  - Any state -> IDLE when synchronised cs goes high. Takes priority over a simultaneous sclk edge.
- Address arithmetic: increment is modulo 2**ADDR_WIDTH, so it wraps from all-ones to 0 with no error.
- Partial words
  - A write word with fewer than DATA_WIDTH bits when cs deasserts is discarded. Memory is unchanged.
  - An aborted read word has no side effects.
- Outputs
  - miso_oe = 1 only in READ.
  - miso_pin = 0 whenever not in READ.
  - busy = 1 in every state except IDLE.
- Reset (synchronous, any time including mid-transaction)
  - State -> IDLE; miso_pin = 0; miso_oe = 0; busy = 0.
  - Counters, addr_reg, data_reg and shift_out are cleared. Synchroniser flip-flops are cleared: sclk and mosi stages to 0, cs stages to 1.
  - RAM contents are NOT reset. An in-flight write that has not reached its commit clk is dropped.
  - After reset the block waits for cs to be high before accepting a new falling edge, so a frame already in progress is ignored.
- Memory: inferred single-port RAM with synchronous write and registered read. Each clk performs at most one access, either read or write.
- fault_pin has no effect on reads, addressing or the bit counter. A suppressed write still advances addr_reg.

Test Plan (ADDR_WIDTH=7, DATA_WIDTH=8, sclk half-period 10 clk):
- Single write then read: write 0x5A, R/W=0, data 0xDB, cs high; new frame reads 0x5A with R/W=1. Expect 0xDB on miso_pin, miso_oe=1 only during the data phase, busy=1 throughout each frame.
- Burst write with wrap: address 0x7E, write 0x11, 0x22, 0x33. Then burst read from 0x7E for 3 words. Expect mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33, and the read returns 0x11, 0x22, 0x33 in that order.
- Partial-word abort: preload mem[0x10]=0xA5; write frame to 0x10 with data 0x3C, cs high after 5 data bits. A subsequent read of 0x10 returns 0xA5.
- Fault injection: preload mem[0x20]=0x0F; write 0xF0 to 0x20 with fault_pin=1. Read returns 0x0F. Repeat with fault_pin=0: read returns 0xF0.
- Reset mid-read: start a read of 0x7E, pulse reset for 1 clk after 3 data bits. Next clk: miso_pin=0, miso_oe=0, busy=0. Raise cs, then a fresh read of 0x7E returns 0x11.
- Idle isolation: toggle sclk and mosi with cs held high for 32 sclk cycles. busy, miso_oe and miso_pin stay 0, and all previously written memory locations are unchanged.
